// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NPORTS clients.
// Optional read-return watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
  parameter int NPORTS  = 4,
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    p_req,
  input  logic [NPORTS-1:0]    p_we,
  input  logic [NPORTS*AW-1:0] p_addr,
  input  logic [NPORTS*DW-1:0] p_data,
  output logic [NPORTS-1:0]    p_ack,
  output logic [NPORTS-1:0]    p_valid,
  output logic [DW-1:0]        p_q,
  output logic                 m_req,
  output logic                 m_we,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_data,
  input  logic                 m_ack,
  input  logic                 m_valid,
  input  logic [DW-1:0]        m_q,
  output logic [NPORTS-1:0]    grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW = $clog2(NPORTS);

  if (NPORTS < 2 || NPORTS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("sdram_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RDWAIT
  } state_t;

  state_t              r_state, w_state_nx;
  logic [PW-1:0]       r_rr, w_rr_nx, w_win;
  logic [NPORTS-1:0]   r_grant, w_grant_nx;
  logic                r_req, w_req_nx;
  logic                r_we, w_we_nx;
  logic [AW-1:0]       r_addr, w_addr_nx;
  logic [DW-1:0]       r_data, w_data_nx;
  logic                w_to;

  // Lowest-priority candidate is visited first so the last hit wins.
  always_comb begin
    int idx;
    w_win = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = int'(r_rr) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (p_req[idx]) w_win = PW'(idx);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rr_nx    = r_rr;
    w_grant_nx = r_grant;
    w_req_nx   = r_req;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    p_ack      = '0;
    p_valid    = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|p_req) begin
          w_grant_nx = NPORTS'(1) << w_win;
          w_we_nx    = p_we[w_win];
          w_addr_nx  = p_addr[int'(w_win)*AW +: AW];
          w_data_nx  = p_data[int'(w_win)*DW +: DW];
          w_req_nx   = 1'b1;
          w_state_nx = S_REQ;
          w_rr_nx    = (int'(w_win) == NPORTS - 1) ? '0 : w_win + 1'b1;
        end
      end
      S_REQ: begin
        if (m_ack) begin
          p_ack    = r_grant;
          w_req_nx = 1'b0;
          if (r_we || m_valid) begin
            p_valid    = r_we ? '0 : r_grant;
            w_grant_nx = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (m_valid) begin
          p_valid    = r_grant;
          w_grant_nx = '0;
          w_state_nx = S_IDLE;
        end else if (w_to) begin
          w_grant_nx = '0;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_grant_nx = '0;
        w_req_nx   = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_grant <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_rr    <= w_rr_nx;
      r_grant <= w_grant_nx;
      r_req   <= w_req_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 256) ? 8 : 16;

  logic [CW-1:0] r_cnt;
  logic          r_terr;

  // Counter is zero on the first RDWAIT cycle and fires on the TIMEOUT-th.
  assign w_to = (r_state == S_RDWAIT) && !m_valid &&
                (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_RDWAIT) ? r_cnt + 1'b1 : '0;
      if (w_to) r_terr <= 1'b1;
    end
  end

  assign timeout_err = r_terr;
`else
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign m_req  = r_req;
  assign m_we   = r_we;
  assign m_addr = r_addr;
  assign m_data = r_data;
  assign grant  = r_grant;
  assign busy   = (r_state != S_IDLE);
  assign p_q    = m_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: transaction table plus corner sequences.
// Timeout sequence is included when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NP-1:0]    p_req, p_we, p_ack, p_valid, grant;
  logic [NP*AW-1:0] p_addr;
  logic [NP*DW-1:0] p_data;
  logic [DW-1:0]    p_q, m_data, m_q;
  logic [AW-1:0]    m_addr;
  logic             m_req, m_we, m_ack, m_valid, busy, timeout_err;

  always #5 clk = ~clk;

  sdram_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
    .p_ack(p_ack), .p_valid(p_valid), .p_q(p_q),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .m_ack(m_ack), .m_valid(m_valid), .m_q(m_q),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic [AW-1:0] A [NP];

  typedef struct {
    logic [3:0] req;
    logic [3:0] we;
    int         exp;
    int         ack_dly;
    int         val_dly;
  } vec_t;

  vec_t tv [12];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Starts at a negedge with the DUT idle, ends at a negedge in IDLE.
  task automatic run(input int id, input vec_t v);
    logic [3:0] g;
    logic       rd;
    g  = 4'b0001 << v.exp;
    rd = ~v.we[v.exp];
    p_req = v.req;
    p_we  = v.we;
    @(negedge clk);
    chk($sformatf("v%0d m_req", id), m_req, 1);
    chk($sformatf("v%0d grant", id), grant, g);
    chk($sformatf("v%0d m_addr", id), m_addr, A[v.exp]);
    chk($sformatf("v%0d m_data", id), m_data, pat(A[v.exp]));
    chk($sformatf("v%0d m_we", id), m_we, !rd);
    chk($sformatf("v%0d busy", id), busy, 1);
    repeat (v.ack_dly) begin
      @(negedge clk);
      chk($sformatf("v%0d hold", id), {m_req, m_addr, p_ack},
          {1'b1, A[v.exp], 4'b0000});
    end
    m_ack   = 1'b1;
    m_valid = rd && (v.val_dly == 0);
    m_q     = pat(A[v.exp]);
    #1;
    chk($sformatf("v%0d p_ack", id), p_ack, g);
    chk($sformatf("v%0d p_valid_ack", id), p_valid,
        (rd && v.val_dly == 0) ? g : 4'b0000);
    @(posedge clk);
    #1;
    m_ack   = 1'b0;
    m_valid = 1'b0;
    p_req[v.exp] = 1'b0;
    if (rd && v.val_dly > 0) begin
      repeat (v.val_dly - 1) begin
        @(negedge clk);
        chk($sformatf("v%0d rdwait", id), {busy, grant, p_valid},
            {1'b1, g, 4'b0000});
      end
      @(negedge clk);
      m_valid = 1'b1;
      #1;
      chk($sformatf("v%0d p_valid", id), p_valid, g);
      chk($sformatf("v%0d p_q", id), p_q, pat(A[v.exp]));
      @(posedge clk);
      #1;
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d idle", id), {busy, m_req, grant}, 6'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    A[0] = 16'h1234;
    A[1] = 16'h0010;
    A[2] = 16'h0005;
    A[3] = 16'h0ABC;
    for (int k = 0; k < NP; k++) begin
      p_addr[k*AW +: AW] = A[k];
      p_data[k*DW +: DW] = pat(A[k]);
    end
    p_req = '0; p_we = '0;
    m_ack = 1'b0; m_valid = 1'b0; m_q = '0;

    // Round-robin from reset, then single transfers and priority picks.
    tv[0]  = '{4'hF, 4'hF, 0, 0, 0};
    tv[1]  = '{4'hF, 4'hF, 1, 0, 0};
    tv[2]  = '{4'hF, 4'hF, 2, 0, 0};
    tv[3]  = '{4'hF, 4'hF, 3, 0, 0};
    tv[4]  = '{4'hF, 4'hF, 0, 0, 0};
    tv[5]  = '{4'hF, 4'hF, 1, 0, 0};
    tv[6]  = '{4'b0010, 4'b0010, 1, 3, 0};
    tv[7]  = '{4'b0100, 4'b0000, 2, 2, 4};
    tv[8]  = '{4'b1000, 4'b0000, 3, 1, 0};
    tv[9]  = '{4'b1010, 4'b1010, 1, 0, 0};
    tv[10] = '{4'b1001, 4'b0001, 3, 0, 1};
    tv[11] = '{4'b0110, 4'b0110, 1, 1, 0};

    #1 reset = 1'b1;
    #2;
    chk("reset_outs", {m_req, m_we, m_addr, m_data, grant, busy, timeout_err},
        '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run(i, tv[i]);

    // Port 0 read in RDWAIT blocks port 3 until data returns.
    p_req = 4'b0001; p_we = 4'b0000;
    @(negedge clk);
    chk("mix grant0", grant, 4'b0001);
    m_ack = 1'b1;
    #1 chk("mix ack0", p_ack, 4'b0001);
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    p_req = 4'b1000; p_we = 4'b1000;
    repeat (3) begin
      @(negedge clk);
      chk("mix hold0", {grant, p_ack}, {4'b0001, 4'b0000});
    end
    m_valid = 1'b1; m_q = pat(A[0]);
    #1 chk("mix valid0", {p_valid, p_q}, {4'b0001, pat(A[0])});
    @(posedge clk);
    #1 m_valid = 1'b0;
    @(negedge clk);
    chk("mix idle gap", {busy, grant}, 5'b0);
    @(negedge clk);
    chk("mix grant3", grant, 4'b1000);
    m_ack = 1'b1;
    #1 chk("mix ack3", p_ack, 4'b1000);
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    p_req = 4'b0000;
    @(negedge clk);
    chk("mix end idle", busy, 0);

    // Stray controller strobes while idle.
    m_valid = 1'b1; m_ack = 1'b1;
    #1 chk("stray", {p_valid, p_ack}, 8'b0);
    @(posedge clk);
    #1;
    m_valid = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    chk("stray idle", {busy, m_req}, 2'b0);

    // Requester withdraws before its ack; transaction still completes.
    p_req = 4'b0100; p_we = 4'b0100;
    @(negedge clk);
    chk("drop grant", grant, 4'b0100);
    p_req = 4'b0000;
    @(negedge clk);
    chk("drop hold", {busy, m_req}, 2'b11);
    m_ack = 1'b1;
    #1 chk("drop ack", p_ack, 4'b0100);
    @(posedge clk);
    #1 m_ack = 1'b0;
    @(negedge clk);
    chk("drop idle", {busy, grant}, 5'b0);

    // Async reset in REQ drops m_req before the next edge and clears rr.
    p_req = 4'b0001; p_we = 4'b0001;
    @(negedge clk);
    chk("rst pre", {m_req, grant}, {1'b1, 4'b0001});
    p_req = 4'b0000;
    reset = 1'b1;
    #1 chk("rst async", {m_req, busy, grant}, 6'b0);
    #2 reset = 1'b0;
    p_req = 4'b1001; p_we = 4'b1001;
    @(negedge clk);
    chk("rst rr", grant, 4'b0001);
    m_ack = 1'b1;
    #1 chk("rst ack", p_ack, 4'b0001);
    @(posedge clk);
    #1;
    m_ack = 1'b0;
    p_req = 4'b0000;
    @(negedge clk);
    chk("rst idle", busy, 0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      logic seen;
      seen = 1'b0;
      p_req = 4'b0010; p_we = 4'b0000;
      @(negedge clk);
      chk("to grant", grant, 4'b0010);
      m_ack = 1'b1;
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      p_req = 4'b0000;
      repeat (16) begin
        @(negedge clk);
        if (p_valid != 4'b0000) seen = 1'b1;
      end
      chk("to before", {busy, timeout_err}, 2'b10);
      @(negedge clk);
      chk("to after", {busy, timeout_err, grant}, {2'b01, 4'b0000});
      chk("to no valid", seen, 0);
      p_req = 4'b0100; p_we = 4'b0100;
      @(negedge clk);
      chk("to next grant", grant, 4'b0100);
      m_ack = 1'b1;
      #1 chk("to next ack", p_ack, 4'b0100);
      @(posedge clk);
      #1;
      m_ack = 1'b0;
      p_req = 4'b0000;
      @(negedge clk);
      chk("to sticky", {busy, timeout_err}, 2'b01);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
